// File: rtl/motion_pkg.sv
// Shared encodings for the drive arbiter: owner codes, direction FSM states,
// idle servo degree and the slew helper used by the speed ramp.
package motion_pkg;

  localparam logic [1:0] OWN_IDLE   = 2'd0;
  localparam logic [1:0] OWN_AUTO   = 2'd1;
  localparam logic [1:0] OWN_REMOTE = 2'd2;

  localparam int DEG_CENTER_DEFAULT = 95;

  typedef enum logic [1:0] {
    ST_DRIVE = 2'd0,
    ST_BRAKE = 2'd1,
    ST_DWELL = 2'd2
  } motion_state_e;

  // Move cur toward tgt by at most step; difference taken at 9 bits, result kept in 0..255.
  function automatic logic [7:0] ramp_toward(input logic [7:0] cur, input logic [7:0] tgt,
                                             input int step);
    logic [8:0] diff;
    logic [9:0] sum;
    logic [7:0] res;
    diff = 9'd0;
    sum  = 10'd0;
    res  = cur;
    if (tgt >= cur) begin
      diff = {1'b0, tgt} - {1'b0, cur};
      if (diff <= 9'(step)) begin
        res = tgt;
      end else begin
        sum = {2'b00, cur} + 10'(step);
        res = (sum > 10'd255) ? 8'hFF : sum[7:0];
      end
    end else begin
      diff = {1'b0, cur} - {1'b0, tgt};
      if (diff <= 9'(step)) begin
        res = tgt;
      end else begin
        res = cur - 8'(step);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/motion_tick_gen.sv
// Free-running divider: one-cycle tick every DIV clocks, first tick DIV clocks
// after reset release.
module motion_tick_gen #(
  parameter int DIV = 50_000
) (
  input  logic clk_50M,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (cnt == CW'(DIV - 1));
      cnt  <= (cnt == CW'(DIV - 1)) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/motion_arbiter.sv
// Drive arbiter: remote > auto > idle ownership, slew-limited speed, brake/dwell
// direction reversal and ultrasonic interlock. MOTION_ARB_WATCHDOG_EN enables the remote watchdog.
module motion_arbiter
  import motion_pkg::*;
#(
  parameter int CLK_HZ            = 50_000_000,
  parameter int STEP_HZ           = 1000,
  parameter int RAMP_STEP         = 1,
  parameter int REMOTE_TIMEOUT_MS = 500,
  parameter int REVERSE_DWELL_MS  = 200,
  parameter int MIN_DIST          = 10,
  parameter int DEG_MIN           = 30,
  parameter int DEG_CENTER        = DEG_CENTER_DEFAULT,
  parameter int DEG_MAX           = 150
) (
  input  logic          clk_50M,
  input  logic          rst_n,
  input  logic          rem_valid,
  input  logic          rem_release,
  input  logic [7:0]    rem_speed,
  input  logic [8:0]    rem_degree,
  input  logic          rem_dir,
  input  logic          auto_en,
  input  logic [7:0]    auto_speed,
  input  logic [8:0]    auto_degree,
  input  logic          auto_dir,
  input  logic [7:0]    forwardDistance,
  input  logic [7:0]    backDistance,
  output logic [7:0]    speed,
  output logic [8:0]    degree,
  output logic          direction,
  output logic [1:0]    owner,
  output logic          interlock,
  output logic          reversing,
  output motion_state_e dbg_state
);

  localparam int TICK_DIV    = CLK_HZ / STEP_HZ;
  localparam int WD_TICKS    = REMOTE_TIMEOUT_MS * STEP_HZ / 1000;
  localparam int DWELL_TICKS = REVERSE_DWELL_MS * STEP_HZ / 1000;

  logic tick;

  motion_tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk_50M (clk_50M),
    .rst_n   (rst_n),
    .tick    (tick)
  );

  logic       rem_own, rem_own_nx, wd_expire;
  logic [7:0] rem_spd_q;
  logic [8:0] rem_deg_q;
  logic       rem_dir_q;

  // A new command always wins over a watchdog expiry in the same cycle.
  always_comb begin
    rem_own_nx = rem_own;
    if (rem_valid)      rem_own_nx = !rem_release;
    else if (wd_expire) rem_own_nx = 1'b0;
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      rem_own   <= 1'b0;
      owner     <= OWN_IDLE;
      rem_spd_q <= 8'd0;
      rem_deg_q <= 9'(DEG_CENTER);
      rem_dir_q <= 1'b1;
    end else begin
      rem_own <= rem_own_nx;
      owner   <= rem_own_nx ? OWN_REMOTE : (auto_en ? OWN_AUTO : OWN_IDLE);
      if (rem_valid) begin
        rem_spd_q <= rem_speed;
        rem_deg_q <= rem_degree;
        rem_dir_q <= rem_dir;
      end
    end
  end

`ifdef MOTION_ARB_WATCHDOG_EN
  logic [15:0] wd_cnt;

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n)                         wd_cnt <= 16'd0;
    else if (rem_valid && !rem_release) wd_cnt <= 16'(WD_TICKS);
    else if (tick && wd_cnt != 16'd0)   wd_cnt <= wd_cnt - 16'd1;
  end

  assign wd_expire = rem_own && (wd_cnt == 16'd0);
`else
  logic wd_unused;
  assign wd_unused = (WD_TICKS == 0);
  assign wd_expire = 1'b0;
`endif

  logic [7:0] tgt_speed;
  logic [8:0] tgt_deg, tgt_deg_cl;
  logic       tgt_dir;

  always_comb begin
    tgt_speed = 8'd0;
    tgt_deg   = 9'(DEG_CENTER);
    tgt_dir   = direction;
    case (owner)
      OWN_REMOTE: begin tgt_speed = rem_spd_q;  tgt_deg = rem_deg_q;   tgt_dir = rem_dir_q; end
      OWN_AUTO:   begin tgt_speed = auto_speed; tgt_deg = auto_degree; tgt_dir = auto_dir;  end
      default:    ;
    endcase
    if (tgt_deg < 9'(DEG_MIN))      tgt_deg_cl = 9'(DEG_MIN);
    else if (tgt_deg > 9'(DEG_MAX)) tgt_deg_cl = 9'(DEG_MAX);
    else                            tgt_deg_cl = tgt_deg;
  end

  logic interlock_c;
  assign interlock_c = direction ? (forwardDistance <= 8'(MIN_DIST))
                                 : (backDistance <= 8'(MIN_DIST));

  motion_state_e state, state_nx;
  logic [15:0]   dwell_cnt;
  logic          dwell_done;

  assign dwell_done = (dwell_cnt == 16'd0);

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) state <= ST_DRIVE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_DRIVE: if (tgt_dir != direction) state_nx = (speed != 8'd0) ? ST_BRAKE : ST_DWELL;
      ST_BRAKE: begin
        if (tgt_dir == direction) state_nx = ST_DRIVE;
        else if (speed == 8'd0)   state_nx = ST_DWELL;
      end
      ST_DWELL: if (tgt_dir == direction || dwell_done) state_nx = ST_DRIVE;
      default:  state_nx = ST_DRIVE;
    endcase
  end

  always_comb begin
    reversing = (state == ST_BRAKE) || (state == ST_DWELL);
    dbg_state = state;
  end

  // Interlock zeroes speed in any state; the dwell counter keeps running underneath it.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      speed     <= 8'd0;
      degree    <= 9'(DEG_CENTER);
      direction <= 1'b1;
      interlock <= 1'b0;
      dwell_cnt <= 16'd0;
    end else begin
      degree    <= tgt_deg_cl;
      interlock <= interlock_c;
      if (state != ST_DWELL && state_nx == ST_DWELL)
        dwell_cnt <= 16'(DWELL_TICKS);
      else if (state == ST_DWELL && tick && !dwell_done)
        dwell_cnt <= dwell_cnt - 16'd1;
      if (state == ST_DWELL && state_nx == ST_DRIVE && tgt_dir != direction)
        direction <= ~direction;
      if (interlock_c) begin
        speed <= 8'd0;
      end else begin
        case (state)
          ST_DRIVE: if (tick) speed <= ramp_toward(speed, tgt_speed, RAMP_STEP);
          ST_BRAKE: if (tick) speed <= ramp_toward(speed, 8'd0, RAMP_STEP);
          default:  speed <= 8'd0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_motion_arbiter.sv
// Directed bench for motion_arbiter with CLK_HZ=1000, STEP_HZ=100, RAMP_STEP=2
// (10-cycle tick, 50-tick watchdog, 20-tick dwell).
module tb_motion_arbiter;
  import motion_pkg::*;

  logic          clk_50M = 1'b0;
  logic          rst_n;
  logic          rem_valid, rem_release, rem_dir, auto_en, auto_dir;
  logic [7:0]    rem_speed, auto_speed, forwardDistance, backDistance;
  logic [8:0]    rem_degree, auto_degree;
  logic [7:0]    speed;
  logic [8:0]    degree;
  logic          direction, interlock, reversing;
  logic [1:0]    owner;
  motion_state_e dbg_state;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [7:0] exp_q[$];

  always #5 clk_50M = ~clk_50M;

  motion_arbiter #(
    .CLK_HZ(1000), .STEP_HZ(100), .RAMP_STEP(2), .REMOTE_TIMEOUT_MS(500),
    .REVERSE_DWELL_MS(200), .MIN_DIST(10), .DEG_MIN(30), .DEG_CENTER(95), .DEG_MAX(150)
  ) dut (
    .clk_50M(clk_50M), .rst_n(rst_n),
    .rem_valid(rem_valid), .rem_release(rem_release), .rem_speed(rem_speed),
    .rem_degree(rem_degree), .rem_dir(rem_dir),
    .auto_en(auto_en), .auto_speed(auto_speed), .auto_degree(auto_degree), .auto_dir(auto_dir),
    .forwardDistance(forwardDistance), .backDistance(backDistance),
    .speed(speed), .degree(degree), .direction(direction), .owner(owner),
    .interlock(interlock), .reversing(reversing), .dbg_state(dbg_state)
  );

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_50M);
    #1;
  endtask

  task automatic wait_speed_change(output int n);
    logic [7:0] old;
    old = speed;
    n = 0;
    while (speed == old && n < 60) begin cyc(1); n++; end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; rem_valid = 1'b0; rem_release = 1'b0; rem_speed = 8'd0; rem_degree = 9'd0;
    rem_dir = 1'b1; auto_en = 1'b0; auto_speed = 8'd0; auto_degree = 9'd95; auto_dir = 1'b1;
    forwardDistance = 8'd100; backDistance = 8'd100;
    cyc(3);
    tests_run++; if (speed !== 8'd0) begin tests_failed++; $display("FAIL reset_speed: got %0d want 0", speed); end
    tests_run++; if (degree !== 9'd95) begin tests_failed++; $display("FAIL reset_degree: got %0d want 95", degree); end
    tests_run++; if (direction !== 1'b1) begin tests_failed++; $display("FAIL reset_dir: got %0d want 1", direction); end
    tests_run++; if (owner !== OWN_IDLE) begin tests_failed++; $display("FAIL reset_owner: got %0d want 0", owner); end
    tests_run++; if (interlock !== 1'b0 || reversing !== 1'b0) begin
      tests_failed++; $display("FAIL reset_flags: got il=%0d rev=%0d want 0/0", interlock, reversing); end
    rst_n = 1'b1;
  endtask

  task automatic test_auto_ramp;
    int n; logic [7:0] e;
    auto_en = 1'b1; auto_speed = 8'd10; auto_degree = 9'd100; auto_dir = 1'b1;
    cyc(1);
    tests_run++; if (owner !== OWN_AUTO) begin tests_failed++; $display("FAIL auto_owner: got %0d want 1", owner); end
    cyc(1);
    tests_run++; if (degree !== 9'd100) begin tests_failed++; $display("FAIL auto_degree: got %0d want 100", degree); end
    for (int v = 2; v <= 10; v += 2) exp_q.push_back(8'(v));
    for (int i = 0; exp_q.size() > 0; i++) begin
      wait_speed_change(n);
      e = exp_q.pop_front();
      tests_run++; if (speed !== e) begin tests_failed++; $display("FAIL auto_ramp: got %0d want %0d", speed, e); end
      if (i > 0) begin
        tests_run++; if (n != 10) begin tests_failed++; $display("FAIL auto_tick_gap: got %0d want 10", n); end
      end
    end
    cyc(30);
    tests_run++; if (speed !== 8'd10) begin tests_failed++; $display("FAIL auto_hold: got %0d want 10", speed); end
  endtask

  task automatic test_remote_override;
    int n; logic [7:0] e;
    rem_valid = 1'b1; rem_release = 1'b0; rem_speed = 8'd20; rem_degree = 9'd200; rem_dir = 1'b1;
    cyc(1);
    rem_valid = 1'b0;
    tests_run++; if (owner !== OWN_REMOTE) begin tests_failed++; $display("FAIL rem_owner: got %0d want 2", owner); end
    cyc(1);
    tests_run++; if (degree !== 9'd150) begin tests_failed++; $display("FAIL rem_clamp_hi: got %0d want 150", degree); end
    for (int v = 12; v <= 20; v += 2) exp_q.push_back(8'(v));
    while (exp_q.size() > 0) begin
      wait_speed_change(n);
      e = exp_q.pop_front();
      tests_run++; if (speed !== e) begin tests_failed++; $display("FAIL rem_ramp: got %0d want %0d", speed, e); end
    end
    rem_valid = 1'b1; rem_degree = 9'd10;
    cyc(1);
    rem_valid = 1'b0;
    cyc(1);
    tests_run++; if (degree !== 9'd30) begin tests_failed++; $display("FAIL rem_clamp_lo: got %0d want 30", degree); end
  endtask

  task automatic test_reversal;
    int n;
    rem_valid = 1'b1; rem_release = 1'b1;
    cyc(1);
    rem_valid = 1'b0; rem_release = 1'b0;
    tests_run++; if (owner !== OWN_AUTO) begin tests_failed++; $display("FAIL release_to_auto: got %0d want 1", owner); end
    n = 0;
    while (speed != 8'd10 && n < 100) begin cyc(1); n++; end
    tests_run++; if (speed !== 8'd10) begin tests_failed++; $display("FAIL rev_pre_speed: got %0d want 10", speed); end
    auto_dir = 1'b0;
    cyc(1);
    tests_run++; if (reversing !== 1'b1 || dbg_state !== ST_BRAKE) begin
      tests_failed++; $display("FAIL rev_brake: got rev=%0d st=%0d want 1/1", reversing, dbg_state); end
    n = 0;
    while (speed != 8'd0 && n < 100) begin cyc(1); n++; end
    tests_run++; if (speed !== 8'd0 || direction !== 1'b1) begin
      tests_failed++; $display("FAIL rev_stopped: got spd=%0d dir=%0d want 0/1", speed, direction); end
    n = 0;
    while (direction == 1'b1 && n < 400) begin cyc(1); n++; end
    tests_run++; if (n != 201) begin tests_failed++; $display("FAIL rev_dwell_len: got %0d want 201 cycles", n); end
    tests_run++; if (direction !== 1'b0 || reversing !== 1'b0) begin
      tests_failed++; $display("FAIL rev_flip: got dir=%0d rev=%0d want 0/0", direction, reversing); end
    wait_speed_change(n);
    tests_run++; if (speed !== 8'd2) begin tests_failed++; $display("FAIL rev_ramp_up: got %0d want 2", speed); end
  endtask

  task automatic test_interlock;
    int n;
    backDistance = 8'd10;
    cyc(1);
    tests_run++; if (speed !== 8'd0 || interlock !== 1'b1) begin
      tests_failed++; $display("FAIL il_back: got spd=%0d il=%0d want 0/1", speed, interlock); end
    backDistance = 8'd11;
    cyc(1);
    tests_run++; if (interlock !== 1'b0) begin tests_failed++; $display("FAIL il_back_rel: got %0d want 0", interlock); end
    wait_speed_change(n);
    tests_run++; if (speed !== 8'd2) begin tests_failed++; $display("FAIL il_back_resume: got %0d want 2", speed); end
    auto_dir = 1'b1; auto_speed = 8'd20;
    n = 0;
    while (direction != 1'b1 && n < 600) begin cyc(1); n++; end
    n = 0;
    while (speed != 8'd20 && n < 300) begin cyc(1); n++; end
    tests_run++; if (speed !== 8'd20 || direction !== 1'b1) begin
      tests_failed++; $display("FAIL il_fwd_pre: got spd=%0d dir=%0d want 20/1", speed, direction); end
    forwardDistance = 8'd8;
    cyc(1);
    tests_run++; if (speed !== 8'd0 || interlock !== 1'b1) begin
      tests_failed++; $display("FAIL il_fwd: got spd=%0d il=%0d want 0/1", speed, interlock); end
    cyc(30);
    tests_run++; if (speed !== 8'd0) begin tests_failed++; $display("FAIL il_fwd_hold: got %0d want 0", speed); end
    forwardDistance = 8'd50;
    cyc(1);
    tests_run++; if (interlock !== 1'b0) begin tests_failed++; $display("FAIL il_fwd_rel: got %0d want 0", interlock); end
    wait_speed_change(n);
    tests_run++; if (speed !== 8'd2) begin tests_failed++; $display("FAIL il_fwd_resume: got %0d want 2", speed); end
  endtask

  task automatic test_watchdog;
    int n;
    auto_en = 1'b0;
    cyc(1);
    tests_run++; if (owner !== OWN_IDLE) begin tests_failed++; $display("FAIL wd_idle: got %0d want 0", owner); end
    rem_valid = 1'b1; rem_release = 1'b0; rem_speed = 8'd6; rem_degree = 9'd90; rem_dir = 1'b1;
    cyc(1);
    rem_valid = 1'b0;
    tests_run++; if (owner !== OWN_REMOTE) begin tests_failed++; $display("FAIL wd_take: got %0d want 2", owner); end
`ifdef MOTION_ARB_WATCHDOG_EN
    n = 0;
    while (owner == OWN_REMOTE && n < 700) begin cyc(1); n++; end
    tests_run++; if (owner !== OWN_IDLE) begin tests_failed++; $display("FAIL wd_expire_owner: got %0d want 0", owner); end
    tests_run++; if (n < 492 || n > 501) begin
      tests_failed++; $display("FAIL wd_expire_time: got %0d want 492..501 cycles", n); end
`else
    cyc(700);
    tests_run++; if (owner !== OWN_REMOTE) begin tests_failed++; $display("FAIL wd_off_hold: got %0d want 2", owner); end
    rem_valid = 1'b1; rem_release = 1'b1;
    cyc(1);
    rem_valid = 1'b0; rem_release = 1'b0;
    tests_run++; if (owner !== OWN_IDLE) begin tests_failed++; $display("FAIL wd_off_release: got %0d want 0", owner); end
`endif
  endtask

  task automatic test_reset_mid_brake;
    int n;
    auto_en = 1'b1; auto_speed = 8'd20; auto_degree = 9'd120; auto_dir = 1'b1;
    n = 0;
    while (speed < 8'd10 && n < 300) begin cyc(1); n++; end
    auto_dir = 1'b0;
    cyc(2);
    tests_run++; if (dbg_state !== ST_BRAKE || speed == 8'd0) begin
      tests_failed++; $display("FAIL mid_brake_pre: got st=%0d spd=%0d want BRAKE/nonzero", dbg_state, speed); end
    rst_n = 1'b0;
    #1;
    tests_run++; if (speed !== 8'd0 || direction !== 1'b1 || degree !== 9'd95 || owner !== OWN_IDLE || reversing !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: got spd=%0d dir=%0d deg=%0d own=%0d rev=%0d want 0/1/95/0/0",
               speed, direction, degree, owner, reversing);
    end
    cyc(2);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish want finish before 1ms");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_auto_ramp();
    test_remote_override();
    test_reversal();
    test_interlock();
    test_watchdog();
    test_reset_mid_brake();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
